i2c_slave_regfile: RTL and testbench
====================================

Name: i2c_slave_regfile

Overview:
- Synthesizable I2C target (slave) that sits directly downstream of i2c_top on the SDA/SCL bus.
- It is the bus partner the master's TX-FIFO traffic lands in; it replaces the behavioural slave model in system benches.
- Write transfers: the first data byte sets a register pointer; following bytes are stored into an internal byte register file with auto-increment.
- Read transfers: bytes are streamed out of the register file from the pointer until the master NACKs.

Parameters:
- SLAVE_ADDR, 7'h20, 7-bit bus address this target answers to.
- MEM_DEPTH, 16, number of 8-bit registers; power of two, 2..256.
- PTR_W, 4, pointer width = log2(MEM_DEPTH).

Ports:
- i2c_core_clk_i  in  1  core clock; ≥8× SCL frequency.
- preset_ni  in  1  asynchronous active-low reset.
- scl_i  in  1  SCL pad input (asynchronous).
- sda_i  in  1  SDA pad input (asynchronous).
- sda_oe_o  out  1  1 = pull SDA low (open-drain); 0 = release.
- wr_strobe_o  out  1  one-cycle pulse when a register byte is written.
- wr_addr_o  out  PTR_W  register index of that write.
- wr_data_o  out  8  byte written.
- dbg_raddr_i  in  PTR_W  side-band register read index.
- dbg_rdata_o  out  8  mem[dbg_raddr_i], combinational.
- busy_o  out  1  high from an addressed START until STOP or NACK-exit.
- stop_o  out  1  one-cycle pulse on any detected STOP.

Behaviour:
- Reset: sda_oe_o=0, wr_strobe_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, stop_o=0, pointer=0, all mem=8'h00, state=IDLE. The reset is asynchronous: sda_oe_o drops to 0 the moment preset_ni falls.
- Input sync: SCL and SDA each pass through a 2-FF synchronizer, plus a registered copy for edge detection.
- Event latency: an SCL/SDA event is seen 3 core cycles after the pad changes.
- START: SDA falls while SCL=1.
- STOP: SDA rises while SCL=1.
- START/STOP take priority over every state, including mid-byte.
  - START → ADDR with the bit counter cleared; a repeated START keeps the pointer.
  - STOP → IDLE with sda_oe_o=0 and a stop_o pulse; a partial byte is discarded and no write occurs.
- Bit timing: SDA is sampled on the synchronized SCL rising edge; sda_oe_o changes only on the SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- ADDR: shift in 8 bits, MSB first.
  - On the 8th falling edge, if addr[7:1]==SLAVE_ADDR: assert sda_oe_o and go to ADDR_ACK; busy_o=1.
  - Otherwise → WAIT_STOP with SDA released.
- ADDR_ACK: on the next falling edge release SDA.
  - R/W=0 → PTR.
  - R/W=1 → load mem[ptr] into the shift register, drive bit7 (sda_oe_o = ~bit) and go to RDATA.
- PTR: after 8 bits, ptr ← byte[PTR_W-1:0] (upper bits ignored), ACK, → PTR_ACK → WDATA.
- WDATA: after 8 bits, in the same cycle as the 8th-bit falling edge:
  - mem[ptr] ← byte and pulse wr_strobe_o, with wr_addr_o=ptr and wr_data_o=byte;
  - ptr ← ptr+1, wrapping modulo MEM_DEPTH;
  - ACK, → WDATA_ACK → WDATA.
- RDATA: shift out bits on falling edges. After the 8th bit, release SDA → RDATA_ACK.
  - Master ACK is sampled on the 9th rising edge.
  - SDA=0 (ACK): ptr++ (wrap), load the next byte, → RDATA.
  - SDA=1 (NACK): → WAIT_STOP.
- WAIT_STOP: SDA released; wait for STOP (→ IDLE) or START (→ ADDR).
- The target never stretches SCL.
- A core write and a dbg read to the same index in the same cycle: dbg_rdata_o shows the old value.

Optional Feature:
- Macro: I2C_SLAVE_GCALL_EN.
- Defined: address byte 8'h00 (general call, write) is ACKed, and the following bytes are handled exactly like a write to SLAVE_ADDR (pointer, then data).
- Undefined: 8'h00 is treated as an address mismatch (no ACK, → WAIT_STOP).

Decomposition:
- Shared package/header i2c_pkg holds:
  - FSM state encodings;
  - ACK=1'b0 and NACK=1'b1;
  - the R/W bit index;
  - the synchronizer depth constant (2).
- Sub-module i2c_slave_sync_edge: 2-FF sync for SCL/SDA plus outputs scl_rise, scl_fall, start_det, stop_det.
- The FSM and register file stay in i2c_slave_regfile.

Test Plan:
- Write 0x40 (0x20<<1|W), 0x03, 0xAA, 0xBB, STOP → ACK after each byte; mem[3]=AA, mem[4]=BB; two wr_strobe_o pulses; stop_o pulse; busy_o back to 0.
- Address 0x42 (0x21) → SDA stays released on the 9th clock (master sees NACK); no writes; state returns to IDLE on STOP.
- Write 0x40, 0x03; repeated START; 0x41; master ACKs once then NACKs → bytes AA, BB driven MSB-first; SDA released after the NACK; STOP → IDLE.
- Write 0x40, 0x0F, 0x11, 0x22 → mem[15]=11, mem[0]=22 (pointer wrap).
- STOP injected after 4 data bits of a WDATA byte → no wr_strobe_o, mem unchanged, IDLE.
- preset_ni low while sda_oe_o=1 during an ACK → sda_oe_o=0 immediately; all outputs at reset values; next transfer works.
- With I2C_SLAVE_GCALL_EN defined: 0x00, 0x05, 0x77 → ACKs and mem[5]=77. Without it: NACK and no write.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-file target: FSM states,
// bus ACK/NACK levels, R/W bit position and synchronizer depth.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } state_e;

  // SDA level on the 9th clock: low acknowledges, high refuses.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Bit of the address byte that carries R/W (1 = read).
  localparam int RW_BIT = 0;

  // Flip-flops between the pads and the first usable copy.
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/i2c_slave_sync_edge.sv
// Pad-side front end: synchronizes SCL/SDA into the core clock domain and
// derives SCL edges plus START/STOP bus conditions. A pad change becomes
// visible as an event three core cycles later.
module i2c_slave_sync_edge
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det
);

  logic [SYNC_DEPTH-1:0] r_scl_sync;
  logic [SYNC_DEPTH-1:0] r_sda_sync;
  logic                  r_scl_d;
  logic                  r_sda_d;
  logic                  w_scl;
  logic                  w_sda;

  // Synchronizer chains plus one delayed copy for edge detection; reset to
  // the idle-bus level (high) so leaving reset never fakes an edge.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_DEPTH-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_DEPTH-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl = r_scl_sync[SYNC_DEPTH-1];
  assign w_sda = r_sda_sync[SYNC_DEPTH-1];

  assign o_sda       = w_sda;
  assign o_scl_rise  =  w_scl & ~r_scl_d;
  assign o_scl_fall  = ~w_scl &  r_scl_d;
  // SDA moving while SCL is stably high is a bus condition, never data.
  assign o_start_det = w_scl & r_scl_d &  r_sda_d & ~w_sda;
  assign o_stop_det  = w_scl & r_scl_d & ~r_sda_d &  w_sda;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte register file. Writes: first byte loads the
// register pointer, following bytes store with auto-increment. Reads stream
// from the pointer until the master NACKs. SCL is never stretched.
// Build option I2C_SLAVE_GCALL_EN: also acknowledge the general-call
// address byte 8'h00 and treat the transfer like a normal write.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h20,
  parameter int         MEM_DEPTH  = 16,
  parameter int         PTR_W      = 4
) (
  input  logic             i2c_core_clk_i,
  input  logic             preset_ni,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe_o,
  output logic             wr_strobe_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  input  logic [PTR_W-1:0] dbg_raddr_i,
  output logic [7:0]       dbg_rdata_o,
  output logic             busy_o,
  output logic             stop_o
);

  logic w_sda, w_scl_rise, w_scl_fall, w_start_det, w_stop_det;

  i2c_slave_sync_edge u_sync (
    .clk         (i2c_core_clk_i),
    .rst_n       (preset_ni),
    .i_scl       (scl_i),
    .i_sda       (sda_i),
    .o_sda       (w_sda),
    .o_scl_rise  (w_scl_rise),
    .o_scl_fall  (w_scl_fall),
    .o_start_det (w_start_det),
    .o_stop_det  (w_stop_det)
  );

  state_e           r_state,     w_state_nxt;
  logic [3:0]       r_bit_cnt,   w_bit_cnt_nxt;
  logic [7:0]       r_shift,     w_shift_nxt;
  logic [PTR_W-1:0] r_ptr,       w_ptr_nxt;
  logic             r_rw,        w_rw_nxt;
  logic             r_sda_oe,    w_sda_oe_nxt;
  logic             r_busy,      w_busy_nxt;
  logic             r_wr_strobe, w_wr_strobe_nxt;
  logic [PTR_W-1:0] r_wr_addr,   w_wr_addr_nxt;
  logic [7:0]       r_wr_data,   w_wr_data_nxt;
  logic             r_stop,      w_stop_nxt;
  logic             w_mem_we;
  logic [7:0]       r_mem [MEM_DEPTH];

  logic w_gcall, w_addr_hit, w_byte_done;

`ifdef I2C_SLAVE_GCALL_EN
  assign w_gcall = (r_shift == 8'h00);
`else
  assign w_gcall = 1'b0;
`endif

  assign w_addr_hit  = (r_shift[7:1] == SLAVE_ADDR) || w_gcall;
  // Eight bits have been clocked in/out and SCL just fell: byte boundary.
  assign w_byte_done = w_scl_fall && (r_bit_cnt == 4'd8);

  // Next-state and next-output logic; bus conditions override every state.
  // NOTE: every variable gets its hold/default value first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_ptr_nxt       = r_ptr;
    w_rw_nxt        = r_rw;
    w_sda_oe_nxt    = r_sda_oe;
    w_busy_nxt      = r_busy;
    w_wr_strobe_nxt = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_stop_nxt      = 1'b0;
    w_mem_we        = 1'b0;

    if (w_stop_det) begin
      w_state_nxt  = IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_stop_nxt   = 1'b1;
    end else if (w_start_det) begin
      // Pointer is deliberately kept so a repeated START can read from it.
      w_state_nxt   = ADDR;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
    end else begin
      // Receive states sample SDA on SCL rise; RDATA only counts bits.
      if (w_scl_rise && (r_state inside {ADDR, PTR, WDATA}))
        w_shift_nxt = {r_shift[6:0], w_sda};
      if (w_scl_rise && (r_state inside {ADDR, PTR, WDATA, RDATA}))
        w_bit_cnt_nxt = r_bit_cnt + 4'd1;

      case (r_state)
        ADDR: if (w_byte_done) begin
          w_bit_cnt_nxt = '0;
          if (w_addr_hit) begin
            w_sda_oe_nxt = ~ACK;
            w_busy_nxt   = 1'b1;
            w_rw_nxt     = r_shift[RW_BIT];
            w_state_nxt  = ADDR_ACK;
          end else begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = WAIT_STOP;
          end
        end
        ADDR_ACK: if (w_scl_fall) begin
          if (r_rw) begin
            w_shift_nxt  = r_mem[r_ptr];
            w_sda_oe_nxt = ~r_mem[r_ptr][7];
            w_state_nxt  = RDATA;
          end else begin
            w_sda_oe_nxt = 1'b0;
            w_state_nxt  = PTR;
          end
        end
        PTR: if (w_byte_done) begin
          w_bit_cnt_nxt = '0;
          w_ptr_nxt     = r_shift[PTR_W-1:0];
          w_sda_oe_nxt  = ~ACK;
          w_state_nxt   = PTR_ACK;
        end
        WDATA: if (w_byte_done) begin
          w_bit_cnt_nxt   = '0;
          w_mem_we        = 1'b1;
          w_wr_strobe_nxt = 1'b1;
          w_wr_addr_nxt   = r_ptr;
          w_wr_data_nxt   = r_shift;
          w_ptr_nxt       = r_ptr + 1'b1;
          w_sda_oe_nxt    = ~ACK;
          w_state_nxt     = WDATA_ACK;
        end
        PTR_ACK, WDATA_ACK: if (w_scl_fall) begin
          w_sda_oe_nxt = 1'b0;
          w_state_nxt  = WDATA;
        end
        RDATA: if (w_scl_fall) begin
          if (r_bit_cnt == 4'd8) begin
            w_sda_oe_nxt = 1'b0;
            w_state_nxt  = RDATA_ACK;
          end else begin
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_sda_oe_nxt = ~r_shift[6];
          end
        end
        RDATA_ACK: begin
          if (w_scl_rise) begin
            if (w_sda == NACK) begin
              w_busy_nxt  = 1'b0;
              w_state_nxt = WAIT_STOP;
            end else begin
              w_ptr_nxt = r_ptr + 1'b1;
            end
          end else if (w_scl_fall) begin
            // Only reached after an ACK; pointer was advanced on the rise.
            w_bit_cnt_nxt = '0;
            w_shift_nxt   = r_mem[r_ptr];
            w_sda_oe_nxt  = ~r_mem[r_ptr][7];
            w_state_nxt   = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge i2c_core_clk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_stop      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_ptr       <= w_ptr_nxt;
      r_rw        <= w_rw_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_wr_strobe <= w_wr_strobe_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_stop      <= w_stop_nxt;
    end
  end

  // Register file write port.
  // NOTE: the register file is reset because software relies on it reading
  // 8'h00 after reset; this forces flops rather than a RAM macro.
  always_ff @(posedge i2c_core_clk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_mem <= '{default: 8'h00};
    end else if (w_mem_we) begin
      r_mem[r_ptr] <= r_shift;
    end
  end

  assign dbg_rdata_o = r_mem[dbg_raddr_i];
  assign sda_oe_o    = r_sda_oe;
  assign wr_strobe_o = r_wr_strobe;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign busy_o      = r_busy;
  assign stop_o      = r_stop;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench for i2c_slave_regfile: a bit-level I2C master drives
// the open-drain bus; a transaction-level model of the register file and
// pointer supplies every expected value.
module tb_i2c_slave_regfile;

  localparam int Q = 60;  // quarter SCL period (6 core cycles)

`ifdef I2C_SLAVE_GCALL_EN
  localparam logic GCALL = 1'b1;
`else
  localparam logic GCALL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       preset_n;
  logic       scl;
  logic       sda_m;
  logic [3:0] dbg_raddr;
  wire        sda_line;
  logic       sda_oe_o, wr_strobe_o, busy_o, stop_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o, dbg_rdata_o;

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe_o;

  i2c_slave_regfile dut (
    .i2c_core_clk_i (clk),
    .preset_ni      (preset_n),
    .scl_i          (scl),
    .sda_i          (sda_line),
    .sda_oe_o       (sda_oe_o),
    .wr_strobe_o    (wr_strobe_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .dbg_raddr_i    (dbg_raddr),
    .dbg_rdata_o    (dbg_rdata_o),
    .busy_o         (busy_o),
    .stop_o         (stop_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_ev_t;
  logic [7:0] m_mem [16];
  int         m_ptr;
  wr_ev_t     exp_wr_q [$];
  wr_ev_t     act_wr_q [$];
  int         stop_cnt = 0;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_ptr = 0;
  endtask

  // Observe output pulses away from the active edge.
  always @(negedge clk) begin
    if (wr_strobe_o) act_wr_q.push_back('{wr_addr_o, wr_data_o});
    if (stop_o) stop_cnt++;
  end

  task automatic compare_writes(input string tag);
    wr_ev_t e, a;
    check({tag, " wr_count"}, act_wr_q.size(), exp_wr_q.size());
    while (exp_wr_q.size() > 0 && act_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      a = act_wr_q.pop_front();
      check({tag, " wr_addr"}, a.a, e.a);
      check({tag, " wr_data"}, a.d, e.d);
    end
    exp_wr_q.delete();
    act_wr_q.delete();
  endtask

  task automatic dbg_check(input int idx, input logic [7:0] exp, input string tag);
    dbg_raddr = 4'(idx);
    #10;
    check($sformatf("%s mem[%0d]", tag, idx), dbg_rdata_o, exp);
  endtask

  // ---------------- bus master ----------------
  task automatic bus_start();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b; #Q; scl = 1'b1; #Q; s = sda_line; #Q; scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(mack, s);
  endtask

  task automatic xfer_write(input logic [7:0] addr, input logic [7:0] p,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                            input int nd, input logic exp_nack, input string tag);
    logic ack;
    logic [7:0] d;
    int stops0;
    stops0 = stop_cnt;
    bus_start();
    write_byte(addr, ack);
    check({tag, " addr_ack"}, ack, exp_nack);
    check({tag, " busy"}, busy_o, !exp_nack);
    if (!exp_nack) begin
      write_byte(p, ack);
      check({tag, " ptr_ack"}, ack, 1'b0);
      m_ptr = int'(p) % 16;
      for (int i = 0; i < nd; i++) begin
        d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
        write_byte(d, ack);
        check($sformatf("%s data%0d_ack", tag, i), ack, 1'b0);
        m_mem[m_ptr] = d;
        exp_wr_q.push_back('{4'(m_ptr), d});
        m_ptr = (m_ptr + 1) % 16;
      end
    end
    bus_stop();
    check({tag, " busy_after_stop"}, busy_o, 1'b0);
    check({tag, " stop_pulses"}, stop_cnt - stops0, 1);
    compare_writes(tag);
  endtask

  task automatic xfer_read(input logic set_ptr, input logic [7:0] p, input int n, input string tag);
    logic ack;
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      write_byte(8'h40, ack);
      check({tag, " waddr_ack"}, ack, 1'b0);
      write_byte(p, ack);
      check({tag, " ptr_ack"}, ack, 1'b0);
      m_ptr = int'(p) % 16;
      bus_start();
    end
    write_byte(8'h41, ack);
    check({tag, " raddr_ack"}, ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      read_byte(d, (i == n - 1) ? 1'b1 : 1'b0);
      check($sformatf("%s byte%0d", tag, i), d, m_mem[m_ptr]);
      if (i < n - 1) m_ptr = (m_ptr + 1) % 16;
    end
    check({tag, " released_after_nack"}, sda_oe_o, 1'b0);
    bus_stop();
    check({tag, " busy_after_stop"}, busy_o, 1'b0);
    compare_writes(tag);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] addr, ptr, d0, d1;
    int         nd;
    logic       exp_nack;
    int         idx0;
    logic [7:0] val0;
    int         idx1;
    logic [7:0] val1;
  } vec_t;
  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       s, ack;
    logic [7:0] b;
    logic [6:0] a7;
    int         op, stops0;

    vecs[0] = '{8'h40, 8'h03, 8'hAA, 8'hBB, 2, 1'b0, 3,  8'hAA, 4, 8'hBB};
    vecs[1] = '{8'h42, 8'h00, 8'h00, 8'h00, 0, 1'b1, 3,  8'hAA, 0, 8'h00};
    vecs[2] = '{8'h40, 8'h0F, 8'h11, 8'h22, 2, 1'b0, 15, 8'h11, 0, 8'h22};
    vecs[3] = '{8'h40, 8'h15, 8'h5A, 8'h00, 1, 1'b0, 5,  8'h5A, 6, 8'h00};
    vecs[4] = '{8'h00, 8'h05, 8'h77, 8'h00, 1, !GCALL, 5, GCALL ? 8'h77 : 8'h5A, 6, 8'h00};

    preset_n = 1'b0; scl = 1'b1; sda_m = 1'b1; dbg_raddr = 4'd0;
    model_reset();
    #2;
    check("rst sda_oe", sda_oe_o, 1'b0);
    check("rst busy", busy_o, 1'b0);
    check("rst wr_strobe", wr_strobe_o, 1'b0);
    check("rst wr_addr", wr_addr_o, 4'd0);
    check("rst wr_data", wr_data_o, 8'd0);
    check("rst stop", stop_o, 1'b0);
    dbg_check(0, 8'h00, "rst");
    #30;
    preset_n = 1'b1;
    #40;

    // Table-driven write transfers.
    for (int i = 0; i < 5; i++) begin
      xfer_write(vecs[i].addr, vecs[i].ptr, vecs[i].d0, vecs[i].d1, 8'h00,
                 vecs[i].nd, vecs[i].exp_nack, $sformatf("vec%0d", i));
      dbg_check(vecs[i].idx0, vecs[i].val0, $sformatf("vec%0d", i));
      dbg_check(vecs[i].idx1, vecs[i].val1, $sformatf("vec%0d", i));
    end

    // Pointer write, repeated START, read AA (ACK) then BB (NACK).
    xfer_read(1'b1, 8'h03, 2, "rd_restart");

    // STOP in the middle of a data byte: no write, pointer still loaded.
    stops0 = stop_cnt;
    bus_start();
    write_byte(8'h40, ack);
    check("midstop addr_ack", ack, 1'b0);
    write_byte(8'h07, ack);
    check("midstop ptr_ack", ack, 1'b0);
    m_ptr = 7;
    b = 8'hB5;
    for (int i = 7; i >= 4; i--) clock_bit(b[i], s);
    bus_stop();
    check("midstop busy", busy_o, 1'b0);
    check("midstop stop_pulses", stop_cnt - stops0, 1);
    compare_writes("midstop");
    dbg_check(7, m_mem[7], "midstop");
    xfer_read(1'b0, 8'h00, 1, "midstop_rd");

    // Reset while the target is driving an address ACK.
    bus_start();
    b = 8'h40;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    check("rstack driving", sda_oe_o, 1'b1);
    preset_n = 1'b0;
    #1;
    check("rstack sda_oe", sda_oe_o, 1'b0);
    check("rstack busy", busy_o, 1'b0);
    check("rstack wr_strobe", wr_strobe_o, 1'b0);
    check("rstack wr_addr", wr_addr_o, 4'd0);
    check("rstack wr_data", wr_data_o, 8'd0);
    check("rstack stop", stop_o, 1'b0);
    #9;
    model_reset();
    dbg_check(3, 8'h00, "rstack");
    #20;
    preset_n = 1'b1;
    #40;
    sda_m = 1'b1; #Q;
    bus_stop();
    act_wr_q.delete();
    xfer_write(8'h40, 8'h02, 8'h5C, 8'h00, 8'h00, 1, 1'b0, "post_rst");
    xfer_read(1'b1, 8'h02, 1, "post_rst_rd");

    // Randomized traffic against the model.
    for (int t = 0; t < 24; t++) begin
      op = $urandom_range(0, 2);
      case (op)
        0: xfer_write(8'h40, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      $urandom_range(1, 3), 1'b0, $sformatf("rnd%0d_wr", t));
        1: xfer_read(1'($urandom), 8'($urandom), $urandom_range(1, 3), $sformatf("rnd%0d_rd", t));
        default: begin
          a7 = 7'($urandom_range(1, 127));
          if (a7 == 7'h20) a7 = 7'h21;
          xfer_write({a7, 1'($urandom)}, 8'($urandom), 8'($urandom), 8'h00, 8'h00,
                     1, 1'b1, $sformatf("rnd%0d_bad", t));
        end
      endcase
    end

    for (int i = 0; i < 16; i++) dbg_check(i, m_mem[i], "final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
